// File: rtl/clk_div_n.sv
// clk_div_n: runtime-programmable integer clock divider with 50% duty cycle
// for both odd and even divisors. The posedge counter produces the first half
// of the high phase. A negedge copy of that flag adds the extra half cycle
// that odd divisors need. Divisor changes are deferred to period boundaries.
module clk_div_n #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div,
  output logic             clk_out,
  output logic             tick,
  output logic             div_ack,
  output logic             div_err,
  output logic [WIDTH-1:0] cur_div
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pf_q, pf_d;
  logic             pos_q, pos_d;
  logic             neg_q;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic wrap, boundary, apply, load_ok;

  // A boundary is any IDLE edge or the last-count edge of a running period.
  // Only there can a new divisor or a stop take effect.
  assign wrap     = (state_q == RUN) && (cnt_q == cur_q - ONE);
  assign boundary = (state_q == IDLE) || wrap;
  assign apply    = boundary && pf_q;
  assign load_ok  = load && (div >= TWO);

  // State register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: decide run/stop only at boundaries so periods are never cut short
  always_comb begin
    state_d = state_q;
    if (boundary) state_d = en ? RUN : IDLE;
  end

  // Datapath/outputs next values: counter, half-period flag, strobes, divisor bookkeeping
  always_comb begin
    cur_d  = apply ? pend_q : cur_q;
    ack_d  = apply;
    cnt_d  = '0;
    pos_d  = 1'b0;
    tick_d = 1'b0;
    if (state_d == RUN) begin
      // A new period (start from IDLE or wrap) always restarts at zero with the
      // divisor that is in effect after this edge.
      cnt_d  = boundary ? '0 : cnt_q + ONE;
      pos_d  = cnt_d < (cur_d >> 1);
      tick_d = (cnt_d == '0);
    end
    // A load on a boundary edge is latched after the old pending value is applied
    pend_d = load_ok ? div : pend_q;
    pf_d   = load_ok | (pf_q & ~apply);
    err_d  = load & ~load_ok;
  end

  // Posedge registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      cur_q  <= DEF;
      pend_q <= DEF;
      pf_q   <= 1'b0;
      pos_q  <= 1'b0;
      tick_q <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cur_q  <= cur_d;
      pend_q <= pend_d;
      pf_q   <= pf_d;
      pos_q  <= pos_d;
      tick_q <= tick_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
    end
  end

  // Negedge copy of the half-period flag: stretches odd-N high time by half a cycle
  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) neg_q <= 1'b0;
    else        neg_q <= pos_q;
  end

  // Both terms are flops and overlap, so the OR cannot glitch. At a wrap both
  // are low, so swapping between odd and even divisors is safe.
  assign clk_out = pos_q | (cur_q[0] & neg_q);
  assign tick    = tick_q;
  assign div_ack = ack_q;
  assign div_err = err_q;
  assign cur_div = cur_q;

endmodule

// File: tb/tb_clk_div_n.sv
// Bench for clk_div_n. The driver runs a period-level model: a period is a
// window [start, start+N) of posedges. Expected ticks, acks and errors are
// queued with their edge number. A monitor samples at every half cycle. It
// pops and compares events and counts high half-cycles per period, which must
// equal N.
module tb_clk_div_n;
  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         rst_n, en, load;
  logic [W-1:0] div;
  logic         clk_out, tick, div_ack, div_err;
  logic [W-1:0] cur_div;

  clk_div_n #(.WIDTH(W), .DEFAULT_DIV(5)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .load(load), .div(div),
    .clk_out(clk_out), .tick(tick), .div_ack(div_ack), .div_err(div_err),
    .cur_div(cur_div)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct { int cyc; int n; } ev_t;
  ev_t tq[$], aq[$], eq[$];

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_run = 0, m_pf = 0;
  int m_start = 0, m_n = 5, m_cur = 5, m_pend = 5;

  // Drive inputs for the next posedge and predict what that edge does
  task automatic step(input logic e_i, input logic l_i, input int d_i);
    int e;
    @(negedge clk_in);
    en = e_i; load = l_i; div = d_i[W-1:0];
    e = cyc + 1;
    if (!m_run || e == m_start + m_n) begin
      if (m_pf) begin
        m_cur = m_pend; m_pf = 0;
        aq.push_back('{e, m_cur});
      end
      if (e_i) begin
        m_run = 1; m_start = e; m_n = m_cur;
        tq.push_back('{e, m_cur});
      end else m_run = 0;
    end
    if (l_i) begin
      if (d_i >= 2) begin m_pend = d_i; m_pf = 1; end
      else eq.push_back('{e, 0});
    end
  endtask

  // ---------------- monitor ----------------
  int hcount = 0, prev_n = 0;
  initial forever begin
    ev_t ev;
    @(posedge clk_in); #2;
    if (!rst_n) begin
      hcount = 0; prev_n = 0;
    end else begin
      while (tq.size() > 0 && tq[0].cyc < cyc) begin
        chk("tick_missed", cyc, tq[0].cyc); void'(tq.pop_front());
      end
      while (aq.size() > 0 && aq[0].cyc < cyc) begin
        chk("ack_missed", cyc, aq[0].cyc); void'(aq.pop_front());
      end
      while (eq.size() > 0 && eq[0].cyc < cyc) begin
        chk("err_missed", cyc, eq[0].cyc); void'(eq.pop_front());
      end
      if (tick) begin
        chk("high_halfcycles", hcount, prev_n);
        if (tq.size() == 0) chk("tick_unexpected", cyc, -1);
        else begin
          ev = tq.pop_front();
          chk("tick_cycle", cyc, ev.cyc);
          chk("tick_cur_div", int'(cur_div), ev.n);
          chk("tick_clk_out_high", int'(clk_out), 1);
          prev_n = ev.n;
        end
        hcount = 0;
      end
      if (clk_out) hcount++;
      if (div_ack) begin
        if (aq.size() == 0) chk("ack_unexpected", cyc, -1);
        else begin
          ev = aq.pop_front();
          chk("ack_cycle", cyc, ev.cyc);
          chk("ack_cur_div", int'(cur_div), ev.n);
        end
      end
      if (div_err) begin
        if (eq.size() == 0) chk("err_unexpected", cyc, -1);
        else begin
          ev = eq.pop_front();
          chk("err_cycle", cyc, ev.cyc);
        end
      end
    end
    @(negedge clk_in); #2;
    if (!rst_n) begin
      hcount = 0; prev_n = 0;
    end else if (clk_out) hcount++;
  end

  // ---------------- stimulus ----------------
  initial begin
    bit en_r;
    int k;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; div = '0;
    #12;
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_div_ack", int'(div_ack), 0);
    chk("rst_div_err", int'(div_err), 0);
    chk("rst_cur_div", int'(cur_div), 5);
    #10 rst_n = 1'b1;

    // default divide-by-5
    repeat (24) step(1, 0, 0);
    // mid-period load of 4
    step(1, 0, 0); step(1, 0, 0);
    step(1, 1, 4);
    repeat (20) step(1, 0, 0);
    // 7 then 3 inside one period: only 3 should land
    step(1, 1, 7); step(1, 1, 3);
    repeat (20) step(1, 0, 0);
    // illegal loads
    step(1, 1, 1); step(1, 0, 0); step(1, 1, 0);
    repeat (10) step(1, 0, 0);
    chk("cur_div_after_err", int'(cur_div), m_cur);
    // N=6, drop en with cnt=1, idle, re-enable
    step(1, 1, 6);
    k = 0;
    while (!(m_run && m_n == 6 && cyc + 1 == m_start + 2) && k < 50) begin
      step(1, 0, 0); k++;
    end
    chk("wait_n6", m_n, 6);
    step(0, 0, 0);
    repeat (15) step(0, 0, 0);
    chk("idle_clk_out", int'(clk_out), 0);
    step(1, 0, 0);
    repeat (12) step(1, 0, 0);

    // randomized traffic
    en_r = 1;
    for (int i = 0; i < 2500; i++) begin
      bit l; int d; int r;
      if ($urandom_range(0, 59) == 0) en_r = ~en_r;
      l = ($urandom_range(0, 14) == 0);
      r = $urandom_range(0, 9);
      if (r == 0)      d = $urandom_range(0, 1);
      else if (r == 1) d = $urandom_range(2, 40);
      else             d = $urandom_range(2, 12);
      step(en_r, l, d);
    end

    // reset while clk_out is high with N=255 and a load still pending
    step(1, 1, 255);
    k = 0;
    while (!(m_run && m_n == 255 && cyc >= m_start + 3) && k < 1000) begin
      step(1, 0, 0); k++;
    end
    chk("wait_n255", m_n, 255);
    step(1, 1, 9);
    @(posedge clk_in); #4;
    chk("pre_reset_high", int'(clk_out), 1);
    rst_n = 1'b0; en = 1'b0; load = 1'b0;
    #1;
    chk("async_rst_clk_out", int'(clk_out), 0);
    chk("async_rst_cur_div", int'(cur_div), 5);
    chk("async_rst_tick", int'(tick), 0);
    chk("async_rst_div_ack", int'(div_ack), 0);
    #11 rst_n = 1'b1;
    m_run = 0; m_pf = 0; m_cur = 5; m_pend = 5;
    tq.delete(); aq.delete(); eq.delete();
    repeat (40) step(1, 0, 0);
    chk("post_rst_cur_div", int'(cur_div), 5);

    // wind down and flush the last period
    repeat (300) step(0, 0, 0);
    @(posedge clk_in); #3;
    chk("final_high_halfcycles", hcount, prev_n);
    chk("tick_q_empty", tq.size(), 0);
    chk("ack_q_empty", aq.size(), 0);
    chk("err_q_empty", eq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
